axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

AXI4-Lite master that converts single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions. It returns each completion on a response port. It sits between host-side control logic (JTAG bridge, sequencers) and the AXI-Lite register slaves of the MASH DAC datapath. It drives the opposite end of the same bus those slaves respond on. One transaction is outstanding at a time.

## Interface
- `TIMEOUT_CYCLES`, default 1024: response-wait watchdog limit, in cycles.
- `m_axi_aclk` in 1: clock.
- `m_axi_aresetn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 selects write, 0 selects read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_write` out 1: echo of `cmd_write`.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP as received.
- `rsp_timeout` out 1: sticky watchdog flag; cleared only by reset.
- `busy` out 1: FSM not in IDLE.
- `m_axi_awaddr` out 32, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write-address channel.
- `m_axi_awprot` out 3: tied to 3'b000.
- `m_axi_wdata` out 32, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write-data channel.
- `m_axi_wstrb` out 4: tied to 4'hF.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write-response channel.
- `m_axi_araddr` out 32, `m_axi_arvalid` out 1, `m_axi_arready` in 1: read-address channel.
- `m_axi_arprot` out 3: tied to 3'b000.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read-data channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: `cmd_ready`=1.
  - On a command handshake, latch address and data.
  - A write goes to WR_REQ and raises `awvalid` and `wvalid` together.
  - A read goes to RD_REQ and raises `arvalid`.
- WR_REQ: the AW and W channels are tracked independently with aw_done and w_done flags.
  - Each valid stays high until its own handshake cycle, then drops on the next edge.
  - Once both channels are done (including both in the same cycle), go to WR_RESP.
- WR_RESP: `bready`=1.
  - On `bvalid`, capture `bresp`, set `rsp_rdata`=0, `rsp_write`=1, and go to DONE.
- RD_REQ: hold `arvalid` until `arready`, then go to RD_RESP.
- RD_RESP: `rready`=1.
  - On `rvalid`, capture `rdata` and `rresp`, set `rsp_write`=0, and go to DONE.
- DONE: `rsp_valid`=1, with all rsp_* fields stable. On `rsp_ready`, return to IDLE.
- AXI stability rules:
  - Address and data outputs never change while their valid is high.
  - A valid is never deasserted before its ready.
  - No output depends combinationally on any `*ready` or `*valid` input.
- Watchdog: a counter runs in WR_REQ, WR_RESP, RD_REQ and RD_RESP, and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, set `rsp_timeout`=1 and keep waiting.
  - The watchdog never abandons a transaction, because that would violate AXI.

## Timing
- All outputs are registered.
- Reset values: all valids/readies = 0, `rsp_*` = 0, `rsp_timeout` = 0, `busy` = 0, state = IDLE, and the address/data registers = 0.
- Asserting reset mid-transaction drops all valids asynchronously. After reset the bus is idle, and the integrator must also reset the slave.
- Write with a zero-wait slave (`awready`/`wready` held at 1, `bvalid` one cycle after the handshake):
  - Command accepted at edge 0.
  - `awvalid` and `wvalid` high in cycle 1.
  - `bready` high in cycle 2.
  - `bvalid` accepted in cycle 3.
  - `rsp_valid` high in cycle 4.
- Read, same conditions: `arvalid` in cycle 1, `rready` in cycle 2, `rsp_valid` in cycle 3 if `rvalid` arrives in cycle 2.
- Slaves that raise ready one cycle after valid add one cycle per channel.
- `cmd_ready`=0 from the accept edge until the edge after the `rsp` handshake. Command throughput is at most one command every 4 cycles.

## Structure
- Shared package `axil_pkg` holds:
  - The `axi_resp_t` enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - The `axil_mst_state_t` FSM enum.
  - The constants AXIL_DATA_W=32 and AXIL_ADDR_W=32.
- Single module; no sub-module is warranted. The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide, inline.

## Test plan
- Write addr 0x0, data 0xDEADBEEF to a slave whose readies lag valid by 1 cycle → exactly one AW and one W handshake, `rsp_resp`=OKAY, `rsp_write`=1; a following read of 0x0 returns `rsp_rdata`=0xDEADBEEF.
- Read addr 0x4 from a slave returning 0 → `rsp_rdata`=0x00000000, `rsp_resp`=00; `arvalid` holds exactly until `arready`.
- Slave accepts W 3 cycles before AW → `wvalid` drops after its handshake, `awvalid` holds until its own, then `bready` rises; no duplicate beats.
- Slave returns SLVERR and `rsp_ready` is held low 5 cycles → `rsp_valid` and `rsp_resp`=2'b10 stay stable for all 5 cycles; `cmd_ready` stays 0 until the handshake.
- TIMEOUT_CYCLES=8 and `bvalid` withheld for 20 cycles → `rsp_timeout`=1 at wait cycle 8, and the transaction still completes when `bvalid` finally arrives.
- Reset asserted while `awvalid`=1 → all valids and `busy` read 0 in the same cycle; after release a new write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and widths for the command master
// and its register-slave peers.
package axil_pkg;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_ADDR_W = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      DONE
   } axil_mst_state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command beat
// into one write or read transaction and returns the completion.
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   m_axi_aclk,
   input  logic                   m_axi_aresetn,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [AXIL_ADDR_W-1:0] cmd_addr,
   input  logic [AXIL_DATA_W-1:0] cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_write,
   output logic [AXIL_DATA_W-1:0] rsp_rdata,
   output logic [1:0]             rsp_resp,
   output logic                   rsp_timeout,
   output logic                   busy,
   output logic [AXIL_ADDR_W-1:0] m_axi_awaddr,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,
   output logic [2:0]             m_axi_awprot,
   output logic [AXIL_DATA_W-1:0] m_axi_wdata,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,
   output logic [3:0]             m_axi_wstrb,
   input  logic [1:0]             m_axi_bresp,
   input  logic                   m_axi_bvalid,
   output logic                   m_axi_bready,
   output logic [AXIL_ADDR_W-1:0] m_axi_araddr,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   output logic [2:0]             m_axi_arprot,
   input  logic [AXIL_DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]             m_axi_rresp,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

   axil_mst_state_t state_q, state_d;

   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;
   logic awvalid_q, awvalid_d;
   logic wvalid_q, wvalid_d;
   logic arvalid_q, arvalid_d;
   logic bready_q, bready_d;
   logic rready_q, rready_d;
   logic cmd_ready_q, cmd_ready_d;
   logic rsp_valid_q, rsp_valid_d;
   logic busy_q, busy_d;
   logic rsp_write_q, rsp_write_d;
   logic timeout_q, timeout_d;

   logic [AXIL_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
   logic [AXIL_ADDR_W-1:0] addr_q, addr_d;
   axi_resp_t              rsp_resp_q, rsp_resp_d;
   logic [CW-1:0]          wdog_q, wdog_d, wdog_inc;

   logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;
   logic aw_ok, w_ok, waiting;

   // Handshakes use only registered valid/ready on our side.
   assign cmd_hs  = cmd_valid & cmd_ready_q;
   assign aw_hs   = awvalid_q & m_axi_awready;
   assign w_hs    = wvalid_q & m_axi_wready;
   assign ar_hs   = arvalid_q & m_axi_arready;
   assign b_hs    = bready_q & m_axi_bvalid;
   assign r_hs    = rready_q & m_axi_rvalid;
   assign rsp_hs  = rsp_valid_q & rsp_ready;
   assign aw_ok   = aw_done_q | aw_hs;
   assign w_ok    = w_done_q | w_hs;
   assign waiting = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_write_q <= 1'b0;
         timeout_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wdata_q     <= '0;
         addr_q      <= '0;
         rsp_resp_q  <= OKAY;
         wdog_q      <= '0;
      end else begin
         state_q     <= state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         rsp_write_q <= rsp_write_d;
         timeout_q   <= timeout_d;
         rsp_rdata_q <= rsp_rdata_d;
         wdata_q     <= wdata_d;
         addr_q      <= addr_d;
         rsp_resp_q  <= rsp_resp_d;
         wdog_q      <= wdog_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_hs) state_d = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
         WR_RESP: if (b_hs) state_d = DONE;
         RD_REQ:  if (ar_hs) state_d = RD_RESP;
         RD_RESP: if (r_hs) state_d = DONE;
         DONE:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      aw_done_d   = 1'b0;
      w_done_d    = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;

      if (state_q == IDLE && cmd_hs) begin
         addr_d    = cmd_addr;
         wdata_d   = cmd_wdata;
         awvalid_d = cmd_write;
         wvalid_d  = cmd_write;
      end

      // Each write channel retires on its own handshake.
      if (state_q == WR_REQ && state_d == WR_REQ) begin
         aw_done_d = aw_ok;
         w_done_d  = w_ok;
         awvalid_d = ~aw_ok;
         wvalid_d  = ~w_ok;
      end

      if (b_hs) begin
         rsp_write_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_resp_d  = axi_resp_t'(m_axi_bresp);
      end

      if (r_hs) begin
         rsp_write_d = 1'b0;
         rsp_rdata_d = m_axi_rdata;
         rsp_resp_d  = axi_resp_t'(m_axi_rresp);
      end

      arvalid_d   = (state_d == RD_REQ);
      bready_d    = (state_d == WR_RESP);
      rready_d    = (state_d == RD_RESP);
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);

      // Watchdog only flags; the transaction is never abandoned.
      wdog_inc  = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
      wdog_d    = '0;
      timeout_d = timeout_q;
      if (waiting) begin
         if (wdog_inc == WD_MAX) timeout_d = 1'b1;
         if (state_d == state_q) wdog_d = wdog_inc;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = timeout_q;
   assign busy          = busy_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a latency-programmable AXI-Lite slave
// with memory, a vector table, and hand-written corner sequences.
module tb_axil_cmd_master;
   import axil_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, busy;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic        m_axi_awvalid, m_axi_awready;
   logic        m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp, m_axi_rresp;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   axil_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .busy(busy),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_awprot(m_axi_awprot),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready), .m_axi_arprot(m_axi_arprot),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // Slave: ready rises after <ch>_d cycles of valid; response after <ch>_d cycles.
   int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
   logic [1:0] s_resp = 2'b00;
   int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   int aw_hs = 0, w_hs = 0, ar_hs = 0;
   logic aw_got, w_got, ar_got;
   logic [31:0] aw_a, w_dat, ar_a;
   logic [31:0] mem [16];

   assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_d);
   assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_d);
   assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_d);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
         aw_a <= '0; w_dat <= '0; ar_a <= '0;
         m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
         m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt <= 0; aw_got <= 1'b1; aw_a <= m_axi_awaddr; aw_hs <= aw_hs + 1;
         end else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
         if (m_axi_wvalid && m_axi_wready) begin
            w_cnt <= 0; w_got <= 1'b1; w_dat <= m_axi_wdata; w_hs <= w_hs + 1;
         end else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
         if (m_axi_arvalid && m_axi_arready) begin
            ar_cnt <= 0; ar_got <= 1'b1; ar_a <= m_axi_araddr; ar_hs <= ar_hs + 1;
         end else if (m_axi_arvalid) ar_cnt <= ar_cnt + 1;
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         else if (aw_got && w_got && !m_axi_bvalid) begin
            if (b_cnt >= b_d) begin
               m_axi_bvalid <= 1'b1; m_axi_bresp <= s_resp;
               mem[aw_a[5:2]] <= w_dat;
               aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else b_cnt <= b_cnt + 1;
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
         else if (ar_got && !m_axi_rvalid) begin
            if (r_cnt >= r_d) begin
               m_axi_rvalid <= 1'b1; m_axi_rresp <= s_resp;
               m_axi_rdata <= mem[ar_a[5:2]];
               ar_got <= 1'b0; r_cnt <= 0;
            end else r_cnt <= r_cnt + 1;
         end
      end
   end

   // Protocol watch: a stalled valid must hold with unchanged payload.
   logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awa, p_wd, p_ara;
   int prot_err = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0;
         p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
         p_awa <= '0; p_wd <= '0; p_ara <= '0;
      end else begin
         prot_err <= prot_err
            + int'(p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awa))
            + int'(p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wd))
            + int'(p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_ara));
         p_awv <= m_axi_awvalid; p_awr <= m_axi_awready; p_awa <= m_axi_awaddr;
         p_wv <= m_axi_wvalid; p_wr <= m_axi_wready; p_wd <= m_axi_wdata;
         p_arv <= m_axi_arvalid; p_arr <= m_axi_arready; p_ara <= m_axi_araddr;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int hold, output logic [31:0] rd,
                          output logic [1:0] rs, output logic rw, output int lat);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cmd_ready_low", 32'(cmd_ready), 32'd0);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
      rd = rsp_rdata; rs = rsp_resp; rw = rsp_write;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_resp", 32'(rsp_resp), 32'(rs));
         chk("hold_rdata", rsp_rdata, rd);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   typedef struct {
      string       nm;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          awd, wd, bd, ard, rd;
      logic [1:0]  sresp;
      int          hold;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   vec_t tv [8];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        rw;
      int          lat, n, aw0, w0, ar0;

      tv[0] = '{"wr_lag",   1'b1, 32'h0,  32'hDEADBEEF, 1, 1, 0, 0, 0, OKAY,   0, 32'h0,        OKAY,   0};
      tv[1] = '{"rd_back",  1'b0, 32'h0,  32'h0,        0, 0, 0, 1, 0, OKAY,   0, 32'hDEADBEEF, OKAY,   0};
      tv[2] = '{"rd_zero",  1'b0, 32'h4,  32'h0,        0, 0, 0, 3, 1, OKAY,   0, 32'h0,        OKAY,   0};
      tv[3] = '{"w_first",  1'b1, 32'h8,  32'h12345678, 4, 1, 1, 0, 0, OKAY,   0, 32'h0,        OKAY,   0};
      tv[4] = '{"slverr",   1'b1, 32'hC,  32'hA5A5A5A5, 1, 1, 0, 0, 0, SLVERR, 5, 32'h0,        SLVERR, 0};
      tv[5] = '{"decerr",   1'b0, 32'h8,  32'h0,        0, 0, 0, 0, 2, DECERR, 1, 32'h12345678, DECERR, 0};
      tv[6] = '{"wr_fast",  1'b1, 32'h10, 32'h0BADF00D, 0, 0, 0, 0, 0, OKAY,   0, 32'h0,        OKAY,   4};
      tv[7] = '{"rd_fast",  1'b0, 32'h10, 32'h0,        0, 0, 0, 0, 0, OKAY,   0, 32'h0BADF00D, OKAY,   4};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                             m_axi_bready, m_axi_rready, rsp_valid, busy,
                             cmd_ready, rsp_timeout, rsp_write}), 32'd0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_resp", 32'(rsp_resp), 32'd0);
      chk("reset_addr", m_axi_awaddr, 32'h0);
      chk("tie_prot_strb", 32'({m_axi_awprot, m_axi_arprot, m_axi_wstrb}), 32'h00F);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         aw_d = tv[i].awd; w_d = tv[i].wd; b_d = tv[i].bd;
         ar_d = tv[i].ard; r_d = tv[i].rd; s_resp = tv[i].sresp;
         aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
         run_cmd(tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].hold, rd, rs, rw, lat);
         chk({tv[i].nm, "_rdata"}, rd, tv[i].exp_rdata);
         chk({tv[i].nm, "_resp"}, 32'(rs), 32'(tv[i].exp_resp));
         chk({tv[i].nm, "_write"}, 32'(rw), 32'(tv[i].wr));
         chk({tv[i].nm, "_aw_beats"}, 32'(aw_hs - aw0), 32'(tv[i].wr));
         chk({tv[i].nm, "_w_beats"}, 32'(w_hs - w0), 32'(tv[i].wr));
         chk({tv[i].nm, "_ar_beats"}, 32'(ar_hs - ar0), 32'(!tv[i].wr));
         if (tv[i].exp_lat != 0)
            chk({tv[i].nm, "_latency"}, 32'(lat), 32'(tv[i].exp_lat));
      end

      // Watchdog: B withheld long past TIMEOUT_CYCLES=8.
      aw_d = 0; w_d = 0; b_d = 20; s_resp = OKAY;
      chk("timeout_pre", 32'(rsp_timeout), 32'd0);
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'h14; cmd_wdata = 32'hCAFEF00D;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (m_axi_bready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("to_bready_rise", 32'(m_axi_bready), 32'd1);
      chk("to_wait0", 32'(rsp_timeout), 32'd0);
      repeat (7) @(negedge clk);
      chk("to_wait7", 32'(rsp_timeout), 32'd0);
      chk("to_still_bready", 32'(m_axi_bready), 32'd1);
      @(negedge clk);
      chk("to_wait8", 32'(rsp_timeout), 32'd1);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("to_rsp_resp", 32'(rsp_resp), 32'd0);
      chk("to_rsp_write", 32'(rsp_write), 32'd1);
      chk("to_sticky", 32'(rsp_timeout), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      b_d = 0;
      run_cmd(1'b0, 32'h14, 32'h0, 0, rd, rs, rw, lat);
      chk("to_readback", rd, 32'hCAFEF00D);

      // Reset while AW is stalled.
      aw_d = 10; w_d = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'h18; cmd_wdata = 32'h5EED1234;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst_pre_awvalid", 32'(m_axi_awvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_drop", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                               m_axi_bready, m_axi_rready, rsp_valid, busy,
                               cmd_ready, rsp_timeout}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      aw_d = 1;
      aw0 = aw_hs;
      run_cmd(1'b1, 32'h18, 32'h5EED1234, 0, rd, rs, rw, lat);
      chk("post_rst_wr_resp", 32'(rs), 32'd0);
      chk("post_rst_aw_beats", 32'(aw_hs - aw0), 32'd1);
      run_cmd(1'b0, 32'h18, 32'h0, 0, rd, rs, rw, lat);
      chk("post_rst_readback", rd, 32'h5EED1234);

      chk("protocol_errors", 32'(prot_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
